// File: rtl/fir_pkg.sv
// Shared constants and state encoding for the time-multiplexed 16-tap FIR.
//   TAPS : number of taps (fixed at 16)
//   DW   : sample/coefficient width, signed
//   PW   : multiplier product width
//   ACCW : accumulator width (product plus log2(TAPS) guard bits)
//   TAPW : tap pointer width
package fir_pkg;

  localparam int unsigned TAPS = 16;
  localparam int unsigned DW   = 16;
  localparam int unsigned PW   = 32;
  localparam int unsigned ACCW = 36;
  localparam int unsigned TAPW = 4;

  typedef enum logic [1:0] {
    StIdle,
    StMac,
    StOut
  } state_e;

endpackage

// File: rtl/booth_multiplier_16x16.sv
// Combinational signed 16x16 radix-4 Booth multiplier.
// Ports:
//   a_i : signed multiplicand
//   b_i : signed multiplier (Booth-recoded)
//   p_o : signed 32-bit product
module booth_multiplier_16x16 (
  input  logic signed [15:0] a_i,
  input  logic signed [15:0] b_i,
  output logic signed [31:0] p_o
);

  logic [16:0] b_ext;
  logic [31:0] a_ext;
  logic [31:0] pp;
  logic [31:0] sum;

  always_comb begin
    a_ext = {{16{a_i[15]}}, a_i};
    b_ext = {b_i, 1'b0};
    pp    = '0;
    sum   = '0;
    // Eight radix-4 digits in {-2,-1,0,+1,+2}; the sum is exact modulo 2^32,
    // which covers the full signed 16x16 range.
    for (int i = 0; i < 8; i++) begin
      case (b_ext[2*i +: 3])
        3'b001, 3'b010: pp = a_ext;
        3'b011:         pp = a_ext << 1;
        3'b100:         pp = -(a_ext << 1);
        3'b101, 3'b110: pp = -a_ext;
        default:        pp = '0;
      endcase
      sum = sum + (pp << (2 * i));
    end
    p_o = sum;
  end

endmodule

// File: rtl/fir_mac_scheduler.sv
// Time-multiplexed MAC controller for a 16-tap FIR. Accepts one sample, then
// walks a single shared multiplier over the 16 delay-line/coefficient pairs
// and presents the accumulated output with a valid/ready handshake.
// Ports:
//   clk, rst              : clock, asynchronous active-high reset
//   in_valid/in_ready     : sample handshake, in_sample is the signed input
//   coef_wr_en/addr/data  : coefficient write port, honoured when coef_wr_ready
//   out_valid/out_ready   : output handshake, out_data is the signed result
//   busy                  : high whenever a sample is being processed/held
module fir_mac_scheduler
  import fir_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic signed [DW-1:0]   in_sample,
  input  logic                   coef_wr_en,
  input  logic [TAPW-1:0]        coef_wr_addr,
  input  logic signed [DW-1:0]   coef_wr_data,
  output logic                   coef_wr_ready,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic signed [ACCW-1:0] out_data,
  output logic                   busy
);

  state_e state_q, state_d;

  logic signed [DW-1:0]   dly_q  [TAPS];
  logic signed [DW-1:0]   coef_q [TAPS];
  logic [TAPW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [TAPW-1:0]        newest_q, newest_d;
  logic [TAPW-1:0]        k_q, k_d;
  logic signed [ACCW-1:0] acc_q, acc_d;
  logic signed [ACCW-1:0] out_data_q, out_data_d;
  logic                   out_valid_q, out_valid_d;

  logic                   idle;
  logic                   sample_we;
  logic                   coef_we;
  logic [TAPW-1:0]        rd_idx;
  logic signed [PW-1:0]   prod;
  logic signed [ACCW-1:0] prod_ext;
  logic signed [ACCW-1:0] acc_sum;

  assign idle      = (state_q == StIdle);
  assign sample_we = idle & in_valid;
  assign coef_we   = idle & coef_wr_en;

  // x[n-k] lives k slots behind the newest sample; 4-bit wrap gives mod 16.
  assign rd_idx = newest_q - k_q;

  booth_multiplier_16x16 u_mult (
    .a_i (dly_q[rd_idx]),
    .b_i (coef_q[k_q]),
    .p_o (prod)
  );

  assign prod_ext = {{(ACCW - PW){prod[PW-1]}}, prod};
  assign acc_sum  = acc_q + prod_ext;

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    newest_d    = newest_q;
    k_d         = k_q;
    acc_d       = acc_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          newest_d = wr_ptr_q;
          wr_ptr_d = wr_ptr_q + 1'b1;
          acc_d    = '0;
          k_d      = '0;
          state_d  = StMac;
        end
      end
      StMac: begin
        acc_d = acc_sum;
        k_d   = k_q + 1'b1;
        if (k_q == TAPW'(TAPS - 1)) begin
          out_data_d  = acc_sum;
          out_valid_d = 1'b1;
          state_d     = StOut;
        end
      end
      StOut: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      wr_ptr_q    <= '0;
      newest_q    <= '0;
      k_q         <= '0;
      acc_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      newest_q    <= newest_d;
      k_q         <= k_d;
      acc_q       <= acc_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < TAPS; i++) begin
        dly_q[i]  <= '0;
        coef_q[i] <= '0;
      end
    end else begin
      if (sample_we) dly_q[wr_ptr_q] <= in_sample;
      if (coef_we)   coef_q[coef_wr_addr] <= coef_wr_data;
    end
  end

  assign in_ready      = idle;
  assign coef_wr_ready = idle;
  assign busy          = ~idle;
  assign out_valid     = out_valid_q;
  assign out_data      = out_data_q;

endmodule
